// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg : shared state encoding and protocol constants for the I2C DAC target
// Revision: 1.0
// ============================================================================
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    CMD      = 4'd3,
    CMD_ACK  = 4'd4,
    MSB      = 4'd5,
    MSB_ACK  = 4'd6,
    LSB      = 4'd7,
    LSB_ACK  = 4'd8,
    RD_BYTE  = 4'd9,
    RD_ACK   = 4'd10,
    IGNORE   = 4'd11
  } i2c_state_e;

  localparam logic [3:0] CMD_WR_UPD = 4'h3;
  localparam logic [3:0] CMD_PTR    = 4'h0;

  localparam logic [6:0] DAC_ADDR   = 7'h10;
  localparam logic [6:0] MUX_ADDR   = 7'h74;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// i2c_line_filter : two-flop synchroniser, glitch filter and edge detect for
//                   one open-drain bus line. Idle level of the bus is high.
// Revision: 1.0
// ============================================================================
module i2c_line_filter #(
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic [3:0] cnt_q;
  logic       level_q;
  logic       rise_q;
  logic       fall_q;

  // The filtered level flips only after FILT_CYC consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 4'(FILT_CYC - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/i2c_dac_target.sv
`default_nettype none
// ============================================================================
// i2c_dac_target : I2C responder emulating the 4-channel offset DAC.
//                  Define I2C_DAC_TARGET_READBACK_EN to support read transfers.
// Revision: 1.0
// ============================================================================
module i2c_dac_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = DAC_ADDR,
  parameter int          NUM_CH    = 4,
  parameter logic [11:0] RESET_VAL = 12'h800,
  parameter int          FILT_CYC  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_oe,
  output logic [12*NUM_CH-1:0] ch_value,
  output logic                 upd_strobe,
  output logic [3:0]           upd_ch,
  output logic                 busy
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_scl_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (scl_i),
    .level_o(w_scl),
    .rise_o (w_scl_rise),
    .fall_o (w_scl_fall)
  );

  i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_sda_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (sda_i),
    .level_o(w_sda),
    .rise_o (w_sda_rise),
    .fall_o (w_sda_fall)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  msb_q, msb_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        strobe_q;
  logic [3:0]  upd_ch_q;
  logic        w_commit;
  logic [11:0] ch_q [NUM_CH];

  logic w_start, w_stop, w_byte_done, w_addr_hit, w_ch_ok;

  assign w_start     = w_sda_fall & w_scl;
  assign w_stop      = w_sda_rise & w_scl;
  assign w_byte_done = (bitcnt_q == 4'd8);
  assign w_ch_ok     = (int'(shreg_q[3:0]) < NUM_CH);

`ifdef I2C_DAC_TARGET_READBACK_EN
  logic        rd_lo_q, rd_lo_d;
  logic [11:0] w_cur;
  logic [7:0]  w_tx;

  always_comb begin
    w_cur = RESET_VAL;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ptr_q == 4'(i)) w_cur = ch_q[i];
    end
  end

  assign w_tx       = rd_lo_q ? {w_cur[3:0], 4'h0} : w_cur[11:4];
  assign w_addr_hit = (shreg_q[7:1] == DEV_ADDR);
`else
  assign w_addr_hit = (shreg_q[7:1] == DEV_ADDR) && !shreg_q[0];
`endif

  // Sampling happens on SCL rise; every decision and sda_oe change on SCL fall.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    msb_d    = msb_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    w_commit = 1'b0;
`ifdef I2C_DAC_TARGET_READBACK_EN
    rd_lo_d  = rd_lo_q;
`endif
    if (w_start) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else if (w_stop) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else if (w_scl_rise) begin
      if (state_q inside {ADDR, CMD, MSB, LSB, RD_BYTE, RD_ACK}) begin
        shreg_d  = {shreg_q[6:0], w_sda};
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (w_scl_fall) begin
      case (state_q)
        ADDR: if (w_byte_done) begin
          if (w_addr_hit) begin
            sda_oe_d = 1'b1;
            state_d  = ADDR_ACK;
          end else begin
            state_d  = IGNORE;
          end
        end
        ADDR_ACK: begin
          sda_oe_d = 1'b0;
          bitcnt_d = '0;
          state_d  = CMD;
`ifdef I2C_DAC_TARGET_READBACK_EN
          if (shreg_q[0]) begin
            rd_lo_d  = 1'b0;
            sda_oe_d = ~w_cur[11];
            state_d  = RD_BYTE;
          end
`endif
        end
        CMD: if (w_byte_done) begin
          if ((shreg_q[7:4] == CMD_WR_UPD || shreg_q[7:4] == CMD_PTR) && w_ch_ok) begin
            sda_oe_d = 1'b1;
            ptr_d    = shreg_q[3:0];
            state_d  = CMD_ACK;
          end else begin
            state_d  = IGNORE;
          end
        end
        CMD_ACK: begin
          sda_oe_d = 1'b0;
          bitcnt_d = '0;
          state_d  = (shreg_q[7:4] == CMD_WR_UPD) ? MSB : IGNORE;
        end
        MSB: if (w_byte_done) begin
          msb_d    = shreg_q;
          sda_oe_d = 1'b1;
          state_d  = MSB_ACK;
        end
        MSB_ACK: begin
          sda_oe_d = 1'b0;
          bitcnt_d = '0;
          state_d  = LSB;
        end
        LSB: if (w_byte_done) begin
          w_commit = 1'b1;
          sda_oe_d = 1'b1;
          state_d  = LSB_ACK;
        end
        LSB_ACK: begin
          sda_oe_d = 1'b0;
          bitcnt_d = '0;
          state_d  = MSB;
        end
`ifdef I2C_DAC_TARGET_READBACK_EN
        RD_BYTE: begin
          if (w_byte_done) begin
            sda_oe_d = 1'b0;
            state_d  = RD_ACK;
          end else begin
            sda_oe_d = ~w_tx[3'(4'd7 - bitcnt_q)];
          end
        end
        RD_ACK: begin
          bitcnt_d = '0;
          if (!shreg_q[0]) begin
            rd_lo_d  = ~rd_lo_q;
            sda_oe_d = rd_lo_q ? ~w_cur[11] : ~w_cur[3];
            state_d  = RD_BYTE;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = IGNORE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      msb_q    <= '0;
      ptr_q    <= '0;
      sda_oe_q <= 1'b0;
      strobe_q <= 1'b0;
      upd_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      msb_q    <= msb_d;
      ptr_q    <= ptr_d;
      sda_oe_q <= sda_oe_d;
      strobe_q <= w_commit;
      if (w_commit) upd_ch_q <= ptr_q;
    end
  end

`ifdef I2C_DAC_TARGET_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_lo_q <= 1'b0;
    else        rd_lo_q <= rd_lo_d;
  end
`endif

  // The low nibble of the LSB byte is dropped: the DAC is 12 bits wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= RESET_VAL;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ptr_q == 4'(i)) ch_q[i] <= {msb_q, shreg_q[7:4]};
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_value[12*gi +: 12] = ch_q[gi];
  end

  assign sda_oe     = sda_oe_q;
  assign upd_strobe = strobe_q;
  assign upd_ch     = upd_ch_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire
